// File: rtl/tmu2_burst_pkg.sv
// Shared constants and lane helpers for the TMU2 burst assembler.
package tmu2_burst_pkg;
    localparam int PIX_W         = 16;
    localparam int PIX_PER_BURST = 16;
    localparam int IDX_W         = 4;
    localparam int BURST_W       = 256;
    localparam int SEL_W         = 16;

    // MSB position of pixel lane idx inside the burst: 255 - 16*idx
    function automatic logic [7:0] lane_msb(input logic [IDX_W-1:0] idx);
        return {~idx, 4'hF};
    endfunction
endpackage

// File: rtl/tmu2_burst_lane_wr.sv
// Inserts one pixel into a burst data/mask pair, optionally starting from an empty line.
module tmu2_burst_lane_wr
    import tmu2_burst_pkg::*;
(
    input  logic [BURST_W-1:0] data_in,
    input  logic [SEL_W-1:0]   sel_in,
    input  logic               clear,
    input  logic [IDX_W-1:0]   idx,
    input  logic [PIX_W-1:0]   color,
    output logic [BURST_W-1:0] data_out,
    output logic [SEL_W-1:0]   sel_out
);
    always_comb begin
        data_out = clear ? '0 : data_in;
        sel_out  = clear ? '0 : sel_in;
        data_out[lane_msb(idx) -: PIX_W] = color;
        sel_out[~idx] = 1'b1;
    end
endmodule

// File: rtl/tmu2_burst_asm.sv
// TMU2 burst assembler: merges same-line pixels into 256-bit FML bursts.
// Build option TMU2_BURST_FULL_EMIT_EN emits a line as soon as all 16 lanes are written.
module tmu2_burst_asm
    import tmu2_burst_pkg::*;
#(
    parameter int fml_depth = 26
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 flush,
    output logic                 busy,
    input  logic                 pipe_stb_i,
    output logic                 pipe_ack_o,
    input  logic [PIX_W-1:0]     color,
    input  logic [fml_depth-2:0] dadr,
    output logic                 pipe_stb_o,
    input  logic                 pipe_ack_i,
    output logic [fml_depth-6:0] burst_addr,
    output logic [SEL_W-1:0]     burst_sel,
    output logic [BURST_W-1:0]   burst_do
);
    localparam int TAG_W = fml_depth - 5;

    logic [TAG_W-1:0]   tag, acc_tag, out_tag;
    logic [IDX_W-1:0]   idx;
    logic [BURST_W-1:0] acc_data, out_data, wr_data;
    logic [SEL_W-1:0]   acc_sel, out_sel, wr_sel;
    logic               acc_valid, out_valid;
    logic               tag_match, out_free, accept, move, clear, acc_full;

    assign tag       = dadr[fml_depth-2:IDX_W];
    assign idx       = dadr[IDX_W-1:0];
    assign tag_match = (tag == acc_tag);
    assign out_free  = ~out_valid | pipe_ack_i;

    assign pipe_ack_o = ~acc_valid | tag_match | out_free;
    assign accept     = pipe_stb_i & pipe_ack_o;

`ifdef TMU2_BURST_FULL_EMIT_EN
    assign acc_full = &acc_sel;
`else
    assign acc_full = 1'b0;
`endif

    // A pixel accepted together with flush wins; flush moves the line on a later cycle.
    assign move  = acc_valid & out_free &
                   ((pipe_stb_i & ~tag_match) | (flush & ~accept) | acc_full);
    assign clear = ~acc_valid | move;

    tmu2_burst_lane_wr u_lane_wr (
        .data_in  (acc_data),
        .sel_in   (acc_sel),
        .clear    (clear),
        .idx      (idx),
        .color    (color),
        .data_out (wr_data),
        .sel_out  (wr_sel)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_valid <= 1'b0;
            acc_tag   <= '0;
            acc_sel   <= '0;
            acc_data  <= '0;
        end else if (accept) begin
            acc_valid <= 1'b1;
            acc_tag   <= tag;
            acc_sel   <= wr_sel;
            acc_data  <= wr_data;
        end else if (move) begin
            acc_valid <= 1'b0;
            acc_sel   <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_sel   <= '0;
            out_data  <= '0;
        end else if (move) begin
            out_valid <= 1'b1;
            out_tag   <= acc_tag;
            out_sel   <= acc_sel;
            out_data  <= acc_data;
        end else if (pipe_ack_i) begin
            out_valid <= 1'b0;
        end
    end

    assign pipe_stb_o = out_valid;
    assign burst_addr = out_tag;
    assign burst_sel  = out_sel;
    assign burst_do   = out_data;
    assign busy       = acc_valid | out_valid;
endmodule
